// File: rtl/addsub_sat_pipe_pkg.sv
// Shared types and constants for the saturating add/subtract pipeline.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  // Widest operand the clamp helpers can describe.
  localparam int MAX_W = 64;

  // Largest signed value of a w-bit word, in the low w bits.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w + 1);
  endfunction

  // Smallest signed value of a w-bit word, in the low w bits.
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_sat_pipe_if.sv
// Operation/result handshake bundle for addsub_sat_pipe.
interface addsub_sat_pipe_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic             sat_en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Ovfl;
  logic             Neg;
  logic             Zero;
  logic [WIDTH-1:0] acc;

  // Side that issues operations and consumes results.
  modport master (
    output in_valid, op, sat_en, A, B, out_ready,
    input  in_ready, out_valid, Sum, Ovfl, Neg, Zero, acc
  );

  // The arithmetic unit itself.
  modport slave (
    input  in_valid, op, sat_en, A, B, out_ready,
    output in_ready, out_valid, Sum, Ovfl, Neg, Zero, acc
  );

endinterface

// File: rtl/addsub_sat_pipe_core.sv
// Combinational signed add/subtract with overflow detect and optional clamp.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] X,
  input  logic signed [WIDTH-1:0] Y,
  input  logic                    sub,
  input  logic                    sat_en,
  input  logic                    load,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovfl
);

  localparam logic [MAX_W-1:0] MAX_FULL = sat_max(WIDTH);
  localparam logic [MAX_W-1:0] MIN_FULL = sat_min(WIDTH);
  localparam logic signed [WIDTH-1:0] SAT_HI = MAX_FULL[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] SAT_LO = MIN_FULL[WIDTH-1:0];

  // Overflow direction follows the sign of X: a positive X can only run off the top.
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] wrapped,
    input logic                    ov,
    input logic                    en,
    input logic                    x_msb
  );
    if (en && ov) return x_msb ? SAT_LO : SAT_HI;
    return wrapped;
  endfunction

  logic [WIDTH-1:0] y_op;
  logic [WIDTH:0]   sum_ext;
  logic             carry_into_msb;
  logic             raw_ovfl;

  // Ripple sum with one extra bit so carry-out of the MSB is visible.
  always_comb begin
    y_op           = sub ? ~Y : Y;
    sum_ext        = {1'b0, X} + {1'b0, y_op} + {{WIDTH{1'b0}}, sub};
    carry_into_msb = X[WIDTH-1] ^ y_op[WIDTH-1] ^ sum_ext[WIDTH-1];
    raw_ovfl       = carry_into_msb ^ sum_ext[WIDTH];
    if (load) begin
      result = X;
      ovfl   = 1'b0;
    end else begin
      result = saturate(sum_ext[WIDTH-1:0], raw_ovfl, sat_en, X[WIDTH-1]);
      ovfl   = raw_ovfl;
    end
  end

endmodule

// File: rtl/addsub_sat_pipe.sv
// Two-stage pipelined saturating add/subtract unit with accumulator and N/Z/V flags.
module addsub_sat_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  addsub_sat_pipe_if.slave bus
);

  logic                    vld_p1;
  op_t                     op_p1;
  logic                    sat_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;

  logic                    vld_p2;
  logic signed [WIDTH-1:0] sum_p2;
  logic                    ovfl_p2;
  logic                    neg_p2;
  logic                    zero_p2;
  logic signed [WIDTH-1:0] acc_p2;

  logic                    s2_adv;
  logic                    in_rdy;
  logic signed [WIDTH-1:0] x_p1;
  logic signed [WIDTH-1:0] y_p1;
  logic signed [WIDTH-1:0] res_p1;
  logic                    ovfl_p1;

  assign s2_adv       = ~vld_p2 | bus.out_ready;
  assign in_rdy       = ~vld_p1 | s2_adv;
  assign bus.in_ready = in_rdy;

  // ---- stage 1: operand register ----

  // Valid bit for the operand stage; drains when S2 takes the op and nothing new arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (bus.in_valid && in_rdy) begin
      vld_p1 <= 1'b1;
    end else if (s2_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  // Operand capture on acceptance; held while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (bus.in_valid && in_rdy) begin
      op_p1  <= bus.op;
      sat_p1 <= bus.sat_en;
      a_p1   <= bus.A;
      b_p1   <= bus.B;
    end
  end

  // ---- stage 2: operand select, arithmetic, result register ----

  // ACC adds A onto the live accumulator, so back-to-back ACCs see the newest value.
  always_comb begin
    x_p1 = (op_p1 == OP_ACC) ? acc_p2 : a_p1;
    y_p1 = (op_p1 == OP_ACC) ? a_p1 : b_p1;
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .X      (x_p1),
    .Y      (y_p1),
    .sub    (op_p1 == OP_SUB),
    .sat_en (sat_p1),
    .load   (op_p1 == OP_LOAD),
    .result (res_p1),
    .ovfl   (ovfl_p1)
  );

  // Result, flags and accumulator load together; all hold while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      ovfl_p2 <= 1'b0;
      neg_p2  <= 1'b0;
      zero_p2 <= 1'b0;
      acc_p2  <= '0;
    end else if (vld_p1 && s2_adv) begin
      vld_p2  <= 1'b1;
      sum_p2  <= res_p1;
      ovfl_p2 <= ovfl_p1;
      neg_p2  <= res_p1[WIDTH-1];
      zero_p2 <= (res_p1 == '0);
      if (op_p1 == OP_ACC || op_p1 == OP_LOAD) acc_p2 <= res_p1;
    end else if (bus.out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.Sum       = sum_p2;
  assign bus.Ovfl      = ovfl_p2;
  assign bus.Neg       = neg_p2;
  assign bus.Zero      = zero_p2;
  assign bus.acc       = acc_p2;

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Bench for addsub_sat_pipe: arithmetic model + scoreboard, with literal spot checks.
module tb_addsub_sat_pipe;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_sat_pipe_if #(.WIDTH(16)) bus ();
  addsub_sat_pipe_if #(.WIDTH(8))  bus8 ();

  addsub_sat_pipe #(.WIDTH(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  addsub_sat_pipe #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [15:0] sum;
    logic        ov;
    logic        n;
    logic        z;
    logic [15:0] acc;
  } res_t;

  res_t        q[$];
  res_t        got[$];
  logic [15:0] m_acc = '0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Reference: true integer result, then range test, clamp and truncate.
  task automatic model_push(input op_t o, input logic s, input logic [15:0] a, input logic [15:0] b);
    int x, y, r;
    logic [31:0] rv;
    res_t e;
    x = (o == OP_ACC) ? int'($signed(m_acc)) : int'($signed(a));
    y = (o == OP_ACC) ? int'($signed(a)) : int'($signed(b));
    case (o)
      OP_LOAD: r = x;
      OP_SUB:  r = x - y;
      default: r = x + y;
    endcase
    e.ov = (o != OP_LOAD) && (r > 32767 || r < -32768);
    if (e.ov && s) r = (r > 0) ? 32767 : -32768;
    rv = r;
    e.sum = rv[15:0];
    e.n = e.sum[15];
    e.z = (e.sum == 16'h0000);
    if (o == OP_ACC || o == OP_LOAD) m_acc = e.sum;
    e.acc = m_acc;
    q.push_back(e);
  endtask

  // Scoreboard: every displayed result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    res_t e, a;
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stream_extra: output Sum=0x%0h with nothing expected", bus.Sum);
      end else begin
        e = q[0];
        a.sum = bus.Sum; a.ov = bus.Ovfl; a.n = bus.Neg; a.z = bus.Zero; a.acc = bus.acc;
        n_cmp++;
        if ({a.sum, a.ov, a.n, a.z, a.acc} !== {e.sum, e.ov, e.n, e.z, e.acc}) begin
          n_fail++;
          $display("FAIL stream: got Sum=%h V=%b N=%b Z=%b acc=%h, expected Sum=%h V=%b N=%b Z=%b acc=%h",
                   a.sum, a.ov, a.n, a.z, a.acc, e.sum, e.ov, e.n, e.z, e.acc);
        end
        if (bus.out_ready) begin
          got.push_back(a);
          void'(q.pop_front());
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the op has been accepted.
  task automatic send(input op_t o, input logic s, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.op = o; bus.sat_en = s; bus.A = a; bus.B = b;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end else begin
      model_push(o, s, a, b);
      n_acc++;
      @(posedge clk); #2;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (q.size() != 0 || bus.out_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.in_valid = 1'b0; bus.op = OP_ADD; bus.sat_en = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op = OP_ADD; bus8.sat_en = 1'b0; bus8.A = '0; bus8.B = '0; bus8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_sum", bus.Sum, 0);
    chk("reset_flags", {bus.Ovfl, bus.Neg, bus.Zero}, 0);
    chk("reset_acc", bus.acc, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Overflowing add, clamped then wrapped; first result also pins the latency.
    send(OP_ADD, 1'b1, 16'h7000, 16'h2000);
    chk("latency_not_early", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("latency_2cyc", bus.out_valid, 1);
    #1;
    send(OP_ADD, 1'b0, 16'h7000, 16'h2000);
    // Subtract edge cases.
    send(OP_SUB, 1'b1, 16'h8000, 16'h0001);
    send(OP_SUB, 1'b1, 16'h0005, 16'h0005);
    send(OP_SUB, 1'b1, 16'h0003, 16'h0007);
    // Back-to-back accumulate into saturation.
    send(OP_LOAD, 1'b1, 16'h7FF0, 16'h0000);
    send(OP_ACC,  1'b1, 16'h0008, 16'h0000);
    send(OP_ACC,  1'b1, 16'h0010, 16'h0000);
    // ADD in between accumulator ops must not disturb acc.
    send(OP_LOAD, 1'b0, 16'h0010, 16'h0000);
    send(OP_ADD,  1'b0, 16'h0005, 16'h0005);
    send(OP_ACC,  1'b0, 16'h0003, 16'h0000);
    drain();

    chk("t1_sat_sum", got[0].sum, 16'h7FFF);
    chk("t1_sat_flags", {got[0].ov, got[0].n, got[0].z}, 3'b100);
    chk("t1_wrap_sum", got[1].sum, 16'h9000);
    chk("t1_wrap_flags", {got[1].ov, got[1].n, got[1].z}, 3'b110);
    chk("t2_min_sum", got[2].sum, 16'h8000);
    chk("t2_min_flags", {got[2].ov, got[2].n}, 2'b11);
    chk("t2_zero", {got[3].sum, got[3].z, got[3].ov}, {16'h0000, 2'b10});
    chk("t2_neg", {got[4].sum, got[4].n}, {16'hFFFC, 1'b1});
    chk("t3_load", got[5].sum, 16'h7FF0);
    chk("t3_acc1", got[6].sum, 16'h7FF8);
    chk("t3_acc2_sat", {got[7].sum, got[7].ov, got[7].acc}, {16'h7FFF, 1'b1, 16'h7FFF});
    chk("t3_add_keeps_acc", {got[9].sum, got[9].acc}, {16'h000A, 16'h0010});
    chk("t3_acc_after_add", got[10].sum, 16'h0013);

    // Backpressure: four ops offered while the output is blocked.
    base = n_acc;
    bus.out_ready = 1'b0;
    fork
      begin
        send(OP_ADD, 1'b0, 16'h0001, 16'h0002);
        send(OP_ADD, 1'b0, 16'h0003, 16'h0004);
        send(OP_SUB, 1'b0, 16'h000A, 16'h0001);
        send(OP_ADD, 1'b0, 16'h0100, 16'h0200);
      end
      begin
        repeat (4) @(posedge clk);
        #3;
        chk("bp_accepted", n_acc - base, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_sum_held", bus.Sum, 16'h0003);
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", got.size(), 15);
    chk("bp_order3", got[13].sum, 16'h0009);
    chk("bp_order4", {got[14].sum, got[14].acc}, {16'h0300, 16'h0013});

    // Asynchronous reset with both stages full.
    send(OP_LOAD, 1'b0, 16'h1234, 16'h0000);
    drain();
    chk("rst_acc_pre", bus.acc, 16'h1234);
    bus.out_ready = 1'b0;
    send(OP_ADD, 1'b0, 16'h0001, 16'h0001);
    send(OP_ADD, 1'b0, 16'h0002, 16'h0002);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_sum", bus.Sum, 0);
    chk("rst_async_acc", bus.acc, 0);
    q.delete();
    m_acc = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    send(OP_ADD, 1'b0, 16'h0001, 16'h0001);
    @(posedge clk); #1;
    chk("rst_after_valid", bus.out_valid, 1);
    chk("rst_after_sum", bus.Sum, 16'h0002);
    #1;
    drain();

    // 8-bit instance.
    bus8.in_valid = 1'b1; bus8.op = OP_ADD; bus8.sat_en = 1'b1; bus8.A = 8'h7F; bus8.B = 8'h01;
    @(posedge clk); #2;
    bus8.op = OP_SUB; bus8.sat_en = 1'b0; bus8.A = 8'h80; bus8.B = 8'h01;
    @(posedge clk); #2;
    bus8.in_valid = 1'b0;
    #1;
    chk("w8_add_sat", {bus8.out_valid, bus8.Sum, bus8.Ovfl, bus8.Neg}, {1'b1, 8'h7F, 1'b1, 1'b0});
    @(posedge clk); #3;
    chk("w8_sub_wrap", {bus8.out_valid, bus8.Sum, bus8.Ovfl, bus8.Neg, bus8.Zero}, {1'b1, 8'h7F, 1'b1, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_sat_pipe.md
Name: addsub_sat_pipe

Overview:
Parametrised, two-stage pipelined signed add/subtract unit with selectable saturation and an internal accumulator.
- Generalises the 16-bit saturating adder to WIDTH bits, with valid/ready handshakes on both sides.
- Adds LOAD and ACC (accumulate) modes and produces N/Z/V flags.
- Sits between the execute-stage operand mux and the flag/writeback logic; it also serves as a streaming accumulator for test datapaths.

Parameters:
WIDTH, 16, operand/result width in bits (two's complement, WIDTH >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream presents an operation
in_ready  output  1  unit can accept an operation this cycle
op  input  2  00 ADD (A+B), 01 SUB (A-B), 10 ACC (acc+A), 11 LOAD (acc<=A)
sat_en  input  1  1: clamp result on overflow; 0: wrap
A  input  WIDTH  operand A
B  input  WIDTH  operand B (ignored for ACC/LOAD)
out_valid  output  1  result registers hold a valid result
out_ready  input  1  downstream accepts the result
Sum  output  WIDTH  result (saturated or wrapped)
Ovfl  output  1  raw signed overflow of the operation, independent of sat_en
Neg  output  1  Sum[WIDTH-1]
Zero  output  1  Sum == 0
acc  output  WIDTH  current accumulator value

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0; Sum, Ovfl, Neg, Zero and acc all 0. Takes effect immediately, mid-operation included; in-flight ops are discarded.
- Stage S1 (operand register): captures op, sat_en, A, B when in_valid & in_ready.
- Stage S2 (result register): computes and loads when s1_valid & s2_adv, where s2_adv = ~out_valid | out_ready.
- Handshake:
  - in_ready = ~s1_valid | s2_adv.
  - Output is consumed when out_valid & out_ready.
  - If S2 is not loading and out_ready=1, out_valid clears.
  - Sum and flags hold stable while out_valid & ~out_ready.
- Latency and throughput: 2 cycles from acceptance to out_valid with out_ready held high; throughput 1 op/cycle. Order is preserved; no op is dropped or duplicated.
- Operand select at S2:
  - X = acc for ACC, else A.
  - Y = A for ACC, else B.
  - sub = (op==SUB): Y is inverted with carry-in 1.
- Overflow: Ovfl = carry into MSB xor carry out of MSB. LOAD forces Ovfl=0 and result=A.
- Saturation (sat_en=1 and Ovfl=1): result = {0,1...1} if X[WIDTH-1]=0, else {1,0...0}. With sat_en=0, the wrapped sum is output.
- Flags are computed on the final (post-saturation) result.
- Accumulator:
  - Updated with the final result in the same edge S2 loads an ACC or LOAD op; ADD/SUB leave acc unchanged.
  - Read combinationally at S2, so back-to-back ACC ops need no forwarding or stall.
- Stall behaviour: while stalled (s2_adv=0), S1 holds and acc does not change.

Decomposition:
- Package addsub_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_ACC, OP_LOAD).
  - Functions sat_max(WIDTH) and sat_min(WIDTH) returning the signed max/min constants.
- Sub-module addsub_core (combinational, param WIDTH):
  - Inputs: X, Y, sub, sat_en, load.
  - Outputs: result, ovfl.
  - Instantiated once inside S2. All pipeline, handshake and accumulator logic stays in addsub_sat_pipe.

Test Plan:
1. ADD A=0x7000 B=0x2000, sat_en=1, out_ready=1 -> 2 cycles later out_valid=1, Sum=0x7FFF, Ovfl=1, Neg=0, Zero=0. Same with sat_en=0 -> Sum=0x9000, Ovfl=1, Neg=1.
2. SUB 0x8000-0x0001, sat_en=1 -> Sum=0x8000, Ovfl=1, Neg=1. SUB 0x0005-0x0005 -> Sum=0x0000, Zero=1, Ovfl=0. SUB 0x0003-0x0007 -> Sum=0xFFFC, Neg=1.
3. Back-to-back LOAD 0x7FF0, ACC 0x0008, ACC 0x0010 with sat_en=1 -> Sums 0x7FF0, 0x7FF8, 0x7FFF (last Ovfl=1), final acc=0x7FFF. An interleaved ADD leaves acc unchanged.
4. Backpressure: out_ready=0 for 5 cycles while offering 4 ops -> exactly 2 accepted then in_ready=0, Sum held stable. After out_ready=1, all 4 results appear in order with no loss or duplicates.
5. Reset mid-stream: rst_n=0 with S1 and S2 valid and acc=0x1234 -> out_valid, Sum and acc go to 0 without waiting for a clock edge. After release, ADD 1+1 -> Sum=0x0002 after 2 cycles.
6. WIDTH=8 instance: ADD 0x7F+0x01, sat_en=1 -> Sum=0x7F, Ovfl=1. SUB 0x80-0x01, sat_en=0 -> Sum=0x7F, Ovfl=1.
